axi_lite_regbank: RTL and testbench

Parametrised AXI4-Lite slave register bank: NUM_OUT read/write control registers drive fabric outputs, and NUM_IN read-only status registers sample fabric inputs. It generalises the fixed four-register output-register IP with configurable width and count, byte strobes, status readback, and SLVERR decoding. It sits between the PS AXI-Lite master port and accelerator control/status logic.

---
 rtl/axi_lite_regbank_pkg.sv | 18 +
 rtl/axi_lite_regbank_if.sv | 40 ++++
 rtl/axi_lite_regbank_decode.sv | 31 +++
 rtl/axi_lite_regbank.sv | 187 ++++++++++++++++++
 tb/tb_axi_lite_regbank.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_regbank_pkg.sv
// Shared types for the AXI4-Lite register bank: response codes and the
// write/read handshake state enums.
package axi_lite_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi_lite_regbank_if.sv
// AXI4-Lite slave-side bundle for the register bank; the master modport
// belongs to the PS/bench side, the slave modport to the register bank.
interface axi_lite_regbank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) ();

  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

endinterface

// File: rtl/axi_lite_regbank_decode.sv
// Word-index decoder: classifies a byte address as output register, input
// register or unmapped, and gives the index within its register group.
module axi_lite_regbank_decode #(
  parameter int ADDR_W  = 8,
  parameter int NUM_OUT = 4,
  parameter int NUM_IN  = 2
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              is_out_o,
  output logic              is_in_o,
  output logic              unmapped_o,
  output logic [ADDR_W-3:0] sel_o
);

  // One extra bit so NUM_OUT+NUM_IN == 2^(ADDR_W-2) still compares correctly
  localparam logic [ADDR_W-2:0] OUT_END = (ADDR_W-1)'(NUM_OUT);
  localparam logic [ADDR_W-2:0] IN_END  = (ADDR_W-1)'(NUM_OUT + NUM_IN);

  logic [ADDR_W-2:0] idx_ext;
  logic              unused_addr_lo;

  assign idx_ext        = {1'b0, addr_i[ADDR_W-1:2]};
  assign unused_addr_lo = ^addr_i[1:0];

  assign is_out_o   = (idx_ext < OUT_END);
  assign is_in_o    = !is_out_o && (idx_ext < IN_END);
  assign unmapped_o = !is_out_o && !is_in_o;
  assign sel_o      = is_in_o ? (addr_i[ADDR_W-1:2] - OUT_END[ADDR_W-3:0])
                              : addr_i[ADDR_W-1:2];

endmodule

// File: rtl/axi_lite_regbank.sv
// Parametrised AXI4-Lite register bank: NUM_OUT RW control registers, NUM_IN RO
// status registers. Define AXI_REGBANK_WRITE_PULSE_EN to add the wr_pulse port.
module axi_lite_regbank
  import axi_lite_regbank_pkg::*;
#(
  parameter int              DATA_W    = 32,
  parameter int              ADDR_W    = 8,
  parameter int              NUM_OUT   = 4,
  parameter int              NUM_IN    = 2,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  axi_lite_regbank_if.slave           s_axi,
  output logic [NUM_OUT*DATA_W-1:0]   out_regs,
  input  logic [((NUM_IN > 0) ? NUM_IN : 1)*DATA_W-1:0] in_regs
`ifdef AXI_REGBANK_WRITE_PULSE_EN
  , output logic [NUM_OUT-1:0]        wr_pulse
`endif
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int STRB_W = DATA_W / 8;

  function automatic logic [DATA_W-1:0] merge_strb(input logic [DATA_W-1:0] old_v,
                                                   input logic [DATA_W-1:0] new_v,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < STRB_W; b++)
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  wr_state_e         wr_state_q, wr_state_d;
  rd_state_e         rd_state_q, rd_state_d;
  logic              aw_held_q, w_held_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [1:0]        bresp_q;
  logic [DATA_W-1:0] rdata_q, rd_data_d;
  logic [1:0]        rresp_q, rd_resp_d;
  logic [DATA_W-1:0] out_q [NUM_OUT];

  logic              w_is_out, w_is_in, w_unmapped;
  logic [IDX_W-1:0]  w_sel;
  logic              r_is_out, r_is_in, r_unmapped;
  logic [IDX_W-1:0]  r_sel;
  logic              aw_hs, w_hs, ar_hs, commit;

  axi_lite_regbank_decode #(.ADDR_W(ADDR_W), .NUM_OUT(NUM_OUT), .NUM_IN(NUM_IN)) u_wr_dec (
    .addr_i(awaddr_q), .is_out_o(w_is_out), .is_in_o(w_is_in),
    .unmapped_o(w_unmapped), .sel_o(w_sel)
  );

  axi_lite_regbank_decode #(.ADDR_W(ADDR_W), .NUM_OUT(NUM_OUT), .NUM_IN(NUM_IN)) u_rd_dec (
    .addr_i(s_axi.S_AXI_ARADDR), .is_out_o(r_is_out), .is_in_o(r_is_in),
    .unmapped_o(r_unmapped), .sel_o(r_sel)
  );

  assign aw_hs  = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
  assign w_hs   = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
  assign ar_hs  = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
  assign commit = (wr_state_q == WR_IDLE) && aw_held_q && w_held_q;

  // Write FSM: state register / next state / outputs
  always_ff @(posedge ACLK) begin
    if (ARESET) wr_state_q <= WR_IDLE;
    else        wr_state_q <= wr_state_d;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WR_IDLE: if (commit) wr_state_d = WR_RESP;
      WR_RESP: if (s_axi.S_AXI_BREADY) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    s_axi.S_AXI_AWREADY = (wr_state_q == WR_IDLE) && !aw_held_q;
    s_axi.S_AXI_WREADY  = (wr_state_q == WR_IDLE) && !w_held_q;
    s_axi.S_AXI_BVALID  = (wr_state_q == WR_RESP);
    s_axi.S_AXI_BRESP   = bresp_q;
  end

  // Write capture: AW and W halves are held independently until both arrive
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (aw_hs) aw_held_q <= 1'b1;
      if (w_hs)  w_held_q  <= 1'b1;
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bresp_q   <= (w_is_in || w_unmapped) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (aw_hs) awaddr_q <= s_axi.S_AXI_AWADDR;
    if (w_hs) begin
      wdata_q <= s_axi.S_AXI_WDATA;
      wstrb_q <= s_axi.S_AXI_WSTRB;
    end
  end

`ifdef AXI_REGBANK_WRITE_PULSE_EN
  logic [NUM_OUT-1:0] wr_pulse_q;
  assign wr_pulse = wr_pulse_q;
`endif

  // Register update, committed on the edge after both halves are held
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int k = 0; k < NUM_OUT; k++) out_q[k] <= RESET_VAL;
`ifdef AXI_REGBANK_WRITE_PULSE_EN
      wr_pulse_q <= '0;
`endif
    end else begin
`ifdef AXI_REGBANK_WRITE_PULSE_EN
      wr_pulse_q <= '0;
`endif
      for (int k = 0; k < NUM_OUT; k++) begin
        if (commit && w_is_out && (w_sel == IDX_W'(k))) begin
          out_q[k] <= merge_strb(out_q[k], wdata_q, wstrb_q);
`ifdef AXI_REGBANK_WRITE_PULSE_EN
          wr_pulse_q[k] <= 1'b1;
`endif
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign out_regs[k*DATA_W +: DATA_W] = out_q[k];
  end

  // Read FSM: state register / next state / outputs
  always_ff @(posedge ACLK) begin
    if (ARESET) rd_state_q <= RD_IDLE;
    else        rd_state_q <= rd_state_d;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RD_IDLE: if (s_axi.S_AXI_ARVALID) rd_state_d = RD_DATA;
      RD_DATA: if (s_axi.S_AXI_RREADY) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    s_axi.S_AXI_ARREADY = (rd_state_q == RD_IDLE);
    s_axi.S_AXI_RVALID  = (rd_state_q == RD_DATA);
    s_axi.S_AXI_RDATA   = rdata_q;
    s_axi.S_AXI_RRESP   = rresp_q;
  end

  // Read mux sees out_q before any same-edge write lands
  always_comb begin
    rd_data_d = '0;
    rd_resp_d = r_unmapped ? RESP_SLVERR : RESP_OKAY;
    for (int k = 0; k < NUM_OUT; k++)
      if (r_is_out && (r_sel == IDX_W'(k))) rd_data_d = out_q[k];
    for (int j = 0; j < NUM_IN; j++)
      if (r_is_in && (r_sel == IDX_W'(j))) rd_data_d = in_regs[j*DATA_W +: DATA_W];
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_data_d;
      rresp_q <= rd_resp_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Self-checking bench for axi_lite_regbank: vector table, hand-built handshake
// sequences, and a randomized run against an array-based register model.
module tb_axi_lite_regbank;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NO = 4;
  localparam int NI = 2;
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  logic              clk = 1'b0;
  logic              rst;
  logic [NO*DW-1:0]  out_regs;
  logic [NI*DW-1:0]  in_regs;
`ifdef AXI_REGBANK_WRITE_PULSE_EN
  logic [NO-1:0]     wr_pulse;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] m_out [NO];

  axi_lite_regbank_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  axi_lite_regbank #(.DATA_W(DW), .ADDR_W(AW), .NUM_OUT(NO), .NUM_IN(NI), .RESET_VAL('0)) dut (
    .ACLK(clk),
    .ARESET(rst),
    .s_axi(bus),
    .out_regs(out_regs),
    .in_regs(in_regs)
`ifdef AXI_REGBANK_WRITE_PULSE_EN
    , .wr_pulse(wr_pulse)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] oreg(input int k);
    return out_regs[k*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_f, w_f, aw_d, w_d;
    int n;
    bus.S_AXI_AWADDR = a; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_BREADY = 1'b1;
    aw_d = 0; w_d = 0; n = 0;
    while (!(aw_d && w_d) && n < 16) begin
      aw_f = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_f  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      tick(); n++;
      if (aw_f) begin aw_d = 1; bus.S_AXI_AWVALID = 1'b0; end
      if (w_f)  begin w_d = 1;  bus.S_AXI_WVALID = 1'b0; end
    end
    n = 0;
    while (!bus.S_AXI_BVALID && n < 16) begin tick(); n++; end
    check("bvalid_seen", bus.S_AXI_BVALID, 1);
    resp = bus.S_AXI_BRESP;
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ar_f;
    int n;
    bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b1;
    n = 0;
    ar_f = 0;
    while (!ar_f && n < 16) begin
      ar_f = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
      tick(); n++;
    end
    bus.S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!bus.S_AXI_RVALID && n < 16) begin tick(); n++; end
    check("rvalid_seen", bus.S_AXI_RVALID, 1);
    d = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    tick();
    bus.S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    vec_t        vt [7];
    logic [1:0]  resp, exp_resp;
    logic [31:0] rd, exp_rd, d, old;
    logic [3:0]  s;
    logic [7:0]  a;
    int          idx;

    rst = 1'b1;
    in_regs = '0;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WDATA = '0;
    bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
    for (int k = 0; k < NO; k++) m_out[k] = '0;
    tick(); tick();
    rst = 1'b0;

    check("rst_awready", bus.S_AXI_AWREADY, 1);
    check("rst_wready", bus.S_AXI_WREADY, 1);
    check("rst_arready", bus.S_AXI_ARREADY, 1);
    check("rst_bvalid", bus.S_AXI_BVALID, 0);
    check("rst_rvalid", bus.S_AXI_RVALID, 0);
    check("rst_bresp", bus.S_AXI_BRESP, 0);
    check("rst_rresp", bus.S_AXI_RRESP, 0);
    check("rst_rdata", bus.S_AXI_RDATA, 0);
    check("rst_out_regs", out_regs, 0);

    in_regs = {32'h13579BDF, 32'hCAFE0000};
    vt[0] = '{8'h00, 32'h0101FFFF, 4'hF, OK,  32'h0101FFFF, OK};
    vt[1] = '{8'h04, 32'hABCD0001, 4'hF, OK,  32'hABCD0001, OK};
    vt[2] = '{8'h08, 32'hDEAD0011, 4'hF, OK,  32'hDEAD0011, OK};
    vt[3] = '{8'h0C, 32'hBEEF0011, 4'hF, OK,  32'hBEEF0011, OK};
    vt[4] = '{8'h10, 32'h12345678, 4'hF, ERR, 32'hCAFE0000, OK};
    vt[5] = '{8'h14, 32'h87654321, 4'hF, ERR, 32'h13579BDF, OK};
    vt[6] = '{8'h18, 32'h55555555, 4'hF, ERR, 32'h00000000, ERR};
    for (int i = 0; i < 7; i++) begin
      axi_write(vt[i].addr, vt[i].wdata, vt[i].strb, resp);
      check($sformatf("tbl%0d_bresp", i), resp, vt[i].bresp);
      if (vt[i].bresp == OK) m_out[vt[i].addr >> 2] = vt[i].wdata;
      axi_read(vt[i].addr, rd, resp);
      check($sformatf("tbl%0d_rdata", i), rd, vt[i].rdata);
      check($sformatf("tbl%0d_rresp", i), resp, vt[i].rresp);
      if (i < NO) check($sformatf("tbl%0d_out_regs", i), oreg(i), vt[i].wdata);
    end
    for (int k = 0; k < NO; k++) check($sformatf("tbl_unchanged%0d", k), oreg(k), m_out[k]);

    // Byte strobes
    axi_write(8'h00, 32'hFFFFFFFF, 4'hF, resp);
    axi_write(8'h00, 32'h11223344, 4'b0101, resp);
    m_out[0] = 32'hFF22FF44;
    axi_read(8'h00, rd, resp);
    check("strb_rdata", rd, 32'hFF22FF44);

    // W two cycles ahead of AW
    bus.S_AXI_WDATA = 32'h5A5A5A5A; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    check("wfirst_wready_low", bus.S_AXI_WREADY, 0);
    tick();
    check("wfirst_no_bvalid", bus.S_AXI_BVALID, 0);
    bus.S_AXI_AWADDR = 8'h0C; bus.S_AXI_AWVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    check("wfirst_bvalid_lat", bus.S_AXI_BVALID, 0);
    check("wfirst_old", oreg(3), m_out[3]);
    tick();
    check("wfirst_bvalid", bus.S_AXI_BVALID, 1);
    check("wfirst_new", oreg(3), 32'h5A5A5A5A);
    tick();
    check("wfirst_bvalid_drop", bus.S_AXI_BVALID, 0);
    check("wfirst_single", oreg(3), 32'h5A5A5A5A);
    bus.S_AXI_BREADY = 1'b0;
    m_out[3] = 32'h5A5A5A5A;

    // AW and W together, BREADY held low for three cycles
    bus.S_AXI_AWADDR = 8'h08; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'h0F0F0F0F; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    check("same_bvalid_lat", bus.S_AXI_BVALID, 0);
    check("same_old", oreg(2), m_out[2]);
    tick();
    check("same_bvalid", bus.S_AXI_BVALID, 1);
    check("same_new", oreg(2), 32'h0F0F0F0F);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("same_bvalid_hold", bus.S_AXI_BVALID, 1);
    end
    bus.S_AXI_BREADY = 1'b1;
    tick();
    check("same_bvalid_drop", bus.S_AXI_BVALID, 0);
    bus.S_AXI_BREADY = 1'b0;
    m_out[2] = 32'h0F0F0F0F;

    // Read and write to register 1 completing on the same edge
    old = m_out[1];
    bus.S_AXI_AWADDR = 8'h04; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'h600DF00D; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_ARADDR = 8'h04; bus.S_AXI_ARVALID = 1'b1;
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    check("rw_edge_rvalid", bus.S_AXI_RVALID, 1);
    check("rw_edge_old", bus.S_AXI_RDATA, old);
    check("rw_edge_reg", oreg(1), 32'h600DF00D);
    bus.S_AXI_RREADY = 1'b1; bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0; bus.S_AXI_BREADY = 1'b0;
    m_out[1] = 32'h600DF00D;

`ifdef AXI_REGBANK_WRITE_PULSE_EN
    bus.S_AXI_AWADDR = 8'h08; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'h0; bus.S_AXI_WSTRB = 4'h0; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    check("pulse_before", wr_pulse, 4'b0000);
    tick();
    check("pulse_on", wr_pulse, 4'b0100);
    tick();
    check("pulse_off", wr_pulse, 4'b0000);
    bus.S_AXI_BREADY = 1'b0;
`endif

    // Randomized traffic against the array model
    for (int it = 0; it < 200; it++) begin
      idx = $urandom_range(0, 7);
      a = 8'(idx * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) in_regs = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        exp_resp = ERR;
        if (idx < NO) begin
          exp_resp = OK;
          for (int b = 0; b < 4; b++)
            if (s[b]) m_out[idx][b*8 +: 8] = d[b*8 +: 8];
        end
        axi_write(a, d, s, resp);
        check($sformatf("rnd%0d_bresp", it), resp, exp_resp);
        if (idx < NO) check($sformatf("rnd%0d_out", it), oreg(idx), m_out[idx]);
      end else begin
        if (idx < NO) begin
          exp_rd = m_out[idx]; exp_resp = OK;
        end else if (idx < NO + NI) begin
          exp_rd = in_regs[(idx - NO)*DW +: DW]; exp_resp = OK;
        end else begin
          exp_rd = '0; exp_resp = ERR;
        end
        axi_read(a, rd, resp);
        check($sformatf("rnd%0d_rdata", it), rd, exp_rd);
        check($sformatf("rnd%0d_rresp", it), resp, exp_resp);
      end
    end

    // Reset while a write response is pending
    bus.S_AXI_AWADDR = 8'h04; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'h77777777; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_BREADY = 1'b0;
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    tick();
    check("abort_bvalid_pending", bus.S_AXI_BVALID, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_bvalid", bus.S_AXI_BVALID, 0);
    check("abort_out_regs", out_regs, 0);
    check("abort_awready", bus.S_AXI_AWREADY, 1);
    for (int k = 0; k < NO; k++) m_out[k] = '0;
    axi_read(8'h04, rd, resp);
    check("abort_readback", rd, m_out[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
